// File: rtl/bsync_transmitter.sv
// bsync_transmitter: source-side BSYNC generator for the ADF4030 subsystem.
// Drives a 50 %-duty square wave with programmable half-period and start
// delay. Ratio changes take effect only at period boundaries, and a stop
// request always lets the current period finish. The rising edge of the
// returned BSYNC echo is timestamped against the internal phase counter.
module bsync_transmitter #(
  parameter int RATIO_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic [RATIO_WIDTH-1:0] ratio,
  input  logic [RATIO_WIDTH-1:0] delay,
  input  logic                   update,
  input  logic                   bsync_echo,
  output logic                   bsync_out,
  output logic                   bsync_oe,
  output logic                   period_start,
  output logic [RATIO_WIDTH:0]   echo_delay,
  output logic                   echo_valid,
  output logic                   config_error,
  output logic [1:0]             state
);

  localparam int PW = RATIO_WIDTH + 1;

  localparam logic [RATIO_WIDTH-1:0] ZERO_R = {RATIO_WIDTH{1'b0}};
  localparam logic [RATIO_WIDTH-1:0] ONE_R  = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]          ZERO_P = {PW{1'b0}};
  localparam logic [PW-1:0]          ONE_P  = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Last phase of a period for half-period r: 2*r-1, computed one bit wider
  // than r so the largest ratio cannot overflow.
  function automatic logic [PW-1:0] last_phase(input logic [RATIO_WIDTH-1:0] r);
    last_phase = {r, 1'b0} - ONE_P;
  endfunction

  // High half of the period: phase below the half-period.
  function automatic logic in_high_half(input logic [PW-1:0] ph,
                                        input logic [RATIO_WIDTH-1:0] r);
    in_high_half = (ph < {1'b0, r});
  endfunction

  // True for the states in which the waveform is being generated.
  function automatic logic is_counting(input state_t st);
    is_counting = (st == ST_RUN) || (st == ST_STOP);
  endfunction

  state_t                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [RATIO_WIDTH-1:0] ratio_active_q, ratio_active_d;
  logic [RATIO_WIDTH-1:0] ratio_pend_q, ratio_pend_d;
  logic                   pend_q, pend_d;
  logic [RATIO_WIDTH-1:0] delay_l_q, delay_l_d;
  logic [RATIO_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   bsync_q, bsync_d;
  logic                   oe_q, oe_d;
  logic                   pstart_q, pstart_d;
  logic [PW-1:0]          echo_delay_q, echo_delay_d;
  logic                   echo_valid_q, echo_valid_d;
  logic                   echo_s1_q, echo_s2_q, echo_s3_q;
  logic                   echo_edge_q, echo_edge_d;

  logic                   wrap_s;
  logic                   active_s;
  logic                   upd_ok_s;
  logic                   upd_bad_s;
  logic                   capture_s;

  // Sequencer next state, phase/delay counters, ratio bookkeeping and sticky error.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    ratio_active_d = ratio_active_q;
    ratio_pend_d   = ratio_pend_q;
    pend_d         = pend_q;
    delay_l_d      = delay_l_q;
    dcnt_d         = dcnt_q;
    cfg_err_d      = cfg_err_q;

    wrap_s    = (phase_q == last_phase(ratio_active_q));
    active_s  = (state_q != ST_IDLE);
    upd_ok_s  = active_s && update && (ratio != ZERO_R);
    upd_bad_s = active_s && update && (ratio == ZERO_R);

    case (state_q)
      ST_IDLE: begin
        phase_d = ZERO_P;
        pend_d  = 1'b0;
        if (enable) begin
          if (ratio != ZERO_R) begin
            ratio_active_d = ratio;
            delay_l_d      = delay;
            dcnt_d         = ZERO_R;
            state_d        = ST_DELAY;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == delay_l_q) begin
          state_d = ST_RUN;
          phase_d = ZERO_P;
        end else begin
          dcnt_d = dcnt_q + ONE_R;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          // A stop request seen on the last cycle ends right here, so no
          // fresh period is begun just to be stopped again.
          phase_d = ZERO_P;
          if (enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + ONE_P;
          if (enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (wrap_s) begin
          phase_d = ZERO_P;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + ONE_P;
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = ZERO_P;
      end
    endcase

    // Pending ratio is committed only at the wrap, and only if it was
    // already pending before this cycle; a coincident update waits a period.
    if (is_counting(state_q) && wrap_s && pend_q) begin
      ratio_active_d = ratio_pend_q;
      pend_d         = 1'b0;
    end else begin
      ratio_active_d = ratio_active_d;
    end

    if (upd_ok_s) begin
      ratio_pend_d = ratio;
      pend_d       = 1'b1;
    end else begin
      ratio_pend_d = ratio_pend_d;
    end

    if (upd_bad_s) begin
      cfg_err_d = 1'b1;
    end else begin
      cfg_err_d = cfg_err_d;
    end
  end

  // Output pins are derived from the next state so they move on the same
  // edge as the state register.
  always_comb begin
    bsync_d  = is_counting(state_d) && in_high_half(phase_d, ratio_active_d);
    pstart_d = is_counting(state_d) && (phase_d == ZERO_P);
    oe_d     = (state_d != ST_IDLE);
  end

  // Echo edge qualification and timestamp capture.
  always_comb begin
    echo_edge_d = echo_s2_q && !echo_s3_q;
    capture_s   = echo_edge_q && is_counting(state_q);
    if (capture_s) begin
      echo_delay_d = phase_q;
      echo_valid_d = 1'b1;
    end else begin
      echo_delay_d = echo_delay_q;
      echo_valid_d = 1'b0;
    end
  end

  // State, counters, registered outputs and echo pipeline with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      phase_q        <= ZERO_P;
      ratio_active_q <= ZERO_R;
      ratio_pend_q   <= ZERO_R;
      pend_q         <= 1'b0;
      delay_l_q      <= ZERO_R;
      dcnt_q         <= ZERO_R;
      cfg_err_q      <= 1'b0;
      bsync_q        <= 1'b0;
      oe_q           <= 1'b0;
      pstart_q       <= 1'b0;
      echo_delay_q   <= ZERO_P;
      echo_valid_q   <= 1'b0;
      echo_s1_q      <= 1'b0;
      echo_s2_q      <= 1'b0;
      echo_s3_q      <= 1'b0;
      echo_edge_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      ratio_active_q <= ratio_active_d;
      ratio_pend_q   <= ratio_pend_d;
      pend_q         <= pend_d;
      delay_l_q      <= delay_l_d;
      dcnt_q         <= dcnt_d;
      cfg_err_q      <= cfg_err_d;
      bsync_q        <= bsync_d;
      oe_q           <= oe_d;
      pstart_q       <= pstart_d;
      echo_delay_q   <= echo_delay_d;
      echo_valid_q   <= echo_valid_d;
      echo_s1_q      <= bsync_echo;
      echo_s2_q      <= echo_s1_q;
      echo_s3_q      <= echo_s2_q;
      echo_edge_q    <= echo_edge_d;
    end
  end

  assign bsync_out    = bsync_q;
  assign bsync_oe     = oe_q;
  assign period_start = pstart_q;
  assign echo_delay   = echo_delay_q;
  assign echo_valid   = echo_valid_q;
  assign config_error = cfg_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_bsync_transmitter.sv
// Scoreboard bench for bsync_transmitter: expected per-cycle waveform and
// echo timestamps are queued as stimulus is applied and popped as the DUT
// produces them.
module tb_bsync_transmitter;

  localparam int RW = 16;

  logic          clk;
  logic          rstn;
  logic          enable;
  logic [RW-1:0] ratio;
  logic [RW-1:0] delay;
  logic          update;
  logic          bsync_echo;
  logic          bsync_out;
  logic          bsync_oe;
  logic          period_start;
  logic [RW:0]   echo_delay;
  logic          echo_valid;
  logic          config_error;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       bo;
    logic       ps;
    logic       oe;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   echo_exp_q[$];

  bsync_transmitter #(.RATIO_WIDTH(RW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .ratio        (ratio),
    .delay        (delay),
    .update       (update),
    .bsync_echo   (bsync_echo),
    .bsync_out    (bsync_out),
    .bsync_oe     (bsync_oe),
    .period_start (period_start),
    .echo_delay   (echo_delay),
    .echo_valid   (echo_valid),
    .config_error (config_error),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-waveform builders (spec model: high for phase < r, start at phase 0).
  function automatic void push_run(int r, int from, int to, logic [1:0] st);
    exp_t e;
    for (int p = from; p <= to; p++) begin
      e.bo = (p < r);
      e.ps = (p == 0);
      e.oe = 1'b1;
      e.st = st;
      sb.push_back(e);
    end
  endfunction

  function automatic void push_fixed(int n, logic [1:0] st);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.bo = 1'b0;
      e.ps = 1'b0;
      e.oe = (st != 2'd0);
      e.st = st;
      sb.push_back(e);
    end
  endfunction

  task automatic apply_reset();
    rstn       = 1'b0;
    enable     = 1'b0;
    update     = 1'b0;
    bsync_echo = 1'b0;
    ratio      = 16'd0;
    delay      = 16'd0;
    sb.delete();
    echo_exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bsync_out, bsync_oe, period_start, echo_valid, config_error, state, echo_delay} !== {5'b00000, 2'd0, 17'd0}) begin
      errors++;
      $display("FAIL reset: got out=%b oe=%b ps=%b ev=%b cerr=%b st=%0d ed=%0d, expected all zero",
               bsync_out, bsync_oe, period_start, echo_valid, config_error, state, echo_delay);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   cyc;
    apply_reset();
    ratio  = 16'd4;
    delay  = 16'd0;
    enable = 1'b1;
    push_fixed(1, 2'd1);
    for (int k = 0; k < 3; k++) push_run(4, 0, 7, 2'd2);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL basic cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    // Stop requested on the last cycle of a period: next cycle is IDLE.
    enable = 1'b0;
    push_fixed(2, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL basic_stop cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
  endtask

  task automatic test_delay_stop();
    exp_t e;
    int   cyc;
    apply_reset();
    ratio  = 16'd3;
    delay  = 16'd5;
    enable = 1'b1;
    push_fixed(6, 2'd1);
    push_run(3, 0, 5, 2'd2);
    push_run(3, 0, 1, 2'd2);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL delay_run cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    // Drop enable mid high phase: period completes in STOP, then IDLE.
    enable = 1'b0;
    push_run(3, 2, 5, 2'd3);
    push_fixed(2, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL stop cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
  endtask

  task automatic test_update();
    exp_t e;
    int   cyc;
    apply_reset();
    ratio  = 16'd4;
    delay  = 16'd0;
    enable = 1'b1;
    push_fixed(1, 2'd1);
    push_run(4, 0, 3, 2'd2);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL upd_pre cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    // Mid-period update: current 8-cycle period completes, then ratio 2.
    ratio  = 16'd2;
    update = 1'b1;
    push_run(4, 4, 7, 2'd2);
    for (int k = 0; k < 3; k++) push_run(2, 0, 3, 2'd2);
    while (sb.size() > 0) begin
      @(negedge clk);
      update = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL upd_mid cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    // Update on the wrap cycle: one more ratio-2 period, then ratio 4.
    ratio  = 16'd4;
    update = 1'b1;
    push_run(2, 0, 3, 2'd2);
    for (int k = 0; k < 2; k++) push_run(4, 0, 7, 2'd2);
    while (sb.size() > 0) begin
      @(negedge clk);
      update = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL upd_wrap cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
  endtask

  task automatic test_config_error();
    exp_t e;
    int   cyc;
    // Start request with ratio 0: error flag, no start.
    apply_reset();
    ratio  = 16'd0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({config_error, bsync_oe, state} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL cfg_start: got cerr=%b oe=%b st=%0d, expected cerr=1 oe=0 st=0",
               config_error, bsync_oe, state);
    end
    // Update with ratio 0 while running: flag set, old ratio continues.
    apply_reset();
    ratio  = 16'd3;
    enable = 1'b1;
    push_fixed(1, 2'd1);
    push_run(3, 0, 2, 2'd2);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL cfg_pre cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    checks++;
    if (config_error !== 1'b0) begin
      errors++;
      $display("FAIL cfg_clear_before: got cerr=%b, expected 0", config_error);
    end
    ratio  = 16'd0;
    update = 1'b1;
    push_run(3, 3, 5, 2'd2);
    for (int k = 0; k < 2; k++) push_run(3, 0, 5, 2'd2);
    while (sb.size() > 0) begin
      @(negedge clk);
      update = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({bsync_out, period_start, bsync_oe, state} !== {e.bo, e.ps, e.oe, e.st}) begin
        errors++;
        $display("FAIL cfg_run cycle %0d: got out=%b ps=%b oe=%b st=%0d, expected out=%b ps=%b oe=%b st=%0d",
                 cyc, bsync_out, period_start, bsync_oe, state, e.bo, e.ps, e.oe, e.st);
      end
      cyc++;
    end
    checks++;
    if (config_error !== 1'b1) begin
      errors++;
      $display("FAIL cfg_sticky: got cerr=%b, expected 1", config_error);
    end
  endtask

  task automatic test_echo();
    logic [7:0] hist;
    int         exp_v;
    int         seen;
    apply_reset();
    ratio  = 16'd8;
    delay  = 16'd0;
    enable = 1'b1;
    hist   = 8'd0;
    seen   = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (echo_valid === 1'b1) begin
        seen++;
        checks++;
        if (echo_exp_q.size() == 0) begin
          errors++;
          $display("FAIL echo_spurious cycle %0d: got echo_valid=1 ed=%0d, expected no pulse", c, echo_delay);
        end else begin
          exp_v = echo_exp_q.pop_front();
          if (echo_delay !== exp_v[RW:0]) begin
            errors++;
            $display("FAIL echo_delay cycle %0d: got %0d, expected %0d", c, echo_delay, exp_v);
          end
        end
      end
      // Echo is bsync_out delayed 7 cycles; each rising edge expects 7+3.
      hist = {hist[6:0], bsync_out};
      if (c < 70) begin
        if (hist[7] && !bsync_echo) echo_exp_q.push_back(10);
        bsync_echo = hist[7];
      end else begin
        bsync_echo = 1'b0;
      end
    end
    checks++;
    if (echo_exp_q.size() != 0 || seen < 3) begin
      errors++;
      $display("FAIL echo_count: got %0d pulses with %0d outstanding, expected all edges reported",
               seen, echo_exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    apply_reset();
    ratio  = 16'd4;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bsync_out, state} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL midrun_pre: got out=%b st=%0d, expected out=1 st=2", bsync_out, state);
    end
    rstn   = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bsync_out, bsync_oe, period_start, echo_valid, config_error, state, echo_delay} !== {5'b00000, 2'd0, 17'd0}) begin
      errors++;
      $display("FAIL midrun_reset: got out=%b oe=%b ps=%b ev=%b cerr=%b st=%0d ed=%0d, expected all zero",
               bsync_out, bsync_oe, period_start, echo_valid, config_error, state, echo_delay);
    end
    @(negedge clk);
    rstn = 1'b1;
    bad  = 0;
    for (int c = 0; c < 16; c++) begin
      bsync_echo = c[1];
      @(negedge clk);
      if (echo_valid !== 1'b0 || state !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_echo: got %0d cycles with echo_valid or non-idle state, expected 0", bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_delay_stop();
    test_update();
    test_config_error();
    test_echo();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
